pipeline_hazard_ctrl: RTL

//  Central pipeline sequencer for the 5-stage MIPS core. Handles three jobs:
//  - detects load-use hazards and drives NoOp_i of the Control unit;
//  - flushes IF/ID on taken branches and on jumps;
//  - freezes the whole pipeline while a multi-cycle data-memory access completes.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 19 +
 rtl/pipeline_hazard_ctrl_load_use_detect.sv | 16 +
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: memory FSM encoding,
// register-index width and the opcodes Control decodes.
package pipeline_hazard_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_DONE   = 2'd2
  } mem_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: the lw in EX writes a register the
// instruction in ID reads. Register $0 never creates a dependency.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic             idex_MemRd_i,
  input  logic [REG_W-1:0] idex_Rt_i,
  input  logic [REG_W-1:0] ifid_Rs_i,
  input  logic [REG_W-1:0] ifid_Rt_i,
  output logic             lu_o
);

  assign lu_o = idex_MemRd_i && (idex_Rt_i != '0) &&
                ((idex_Rt_i == ifid_Rs_i) || (idex_Rt_i == ifid_Rt_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: multi-cycle data-memory FSM with timeout, load-use
// bubble insertion and IF/ID flush on taken branches and jumps.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              exmem_MemRd_i,
  input  logic              exmem_MemWr_i,
  input  logic              idex_MemRd_i,
  input  logic [REG_W-1:0]  idex_Rt_i,
  input  logic [REG_W-1:0]  ifid_Rs_i,
  input  logic [REG_W-1:0]  ifid_Rt_i,
  input  logic              Branch_taken_i,
  input  logic              Jump_i,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              PCWrite_o,
  output logic              IFIDWrite_o,
  output logic              IFIDFlush_o,
  output logic              NoOp_o,
  output logic              Stall_o,
  output logic              MemErr_o
);

  mem_state_e       state;
  logic [CNT_W-1:0] count;
  logic             mem_op;
  logic             lu;

  assign mem_op = exmem_MemRd_i | exmem_MemWr_i;

  load_use_detect u_load_use_detect (
    .idex_MemRd_i (idex_MemRd_i),
    .idex_Rt_i    (idex_Rt_i),
    .ifid_Rs_i    (ifid_Rs_i),
    .ifid_Rt_i    (ifid_Rt_i),
    .lu_o         (lu)
  );

  // mem_req_o is registered so it is high for exactly the ACCESS cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= MEM_IDLE;
      count       <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_rdata_o <= '0;
      MemErr_o    <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          count <= '0;
          if (mem_op) begin
            state     <= MEM_ACCESS;
            mem_req_o <= 1'b1;
            mem_we_o  <= exmem_MemWr_i;
          end
        end
        MEM_ACCESS: begin
          count <= count + 1'b1;
          // An ack on the final permitted cycle still counts as success.
          if (mem_ack_i) begin
            if (!mem_we_o) mem_rdata_o <= mem_rdata_i;
            state     <= MEM_DONE;
            mem_req_o <= 1'b0;
          end else if (count == CNT_W'(MEM_TIMEOUT - 1)) begin
            MemErr_o  <= 1'b1;
            state     <= MEM_DONE;
            mem_req_o <= 1'b0;
          end
        end
        MEM_DONE: begin
          state     <= MEM_IDLE;
          count     <= '0;
          mem_req_o <= 1'b0;
        end
        default: begin
          state     <= MEM_IDLE;
          count     <= '0;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

  assign Stall_o = ((state == MEM_IDLE) && mem_op) || (state == MEM_ACCESS);

  // Memory freeze dominates; a load-use bubble dominates a flush so the
  // branch or jump is re-evaluated once the hazard clears.
  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    NoOp_o      = 1'b0;
    if (Stall_o) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (lu) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      NoOp_o      = 1'b1;
    end else if (Branch_taken_i || Jump_i) begin
      IFIDFlush_o = 1'b1;
    end
  end

endmodule
